// File: rtl/dnn_pkg.sv
// Shared DNN datapath constants and the dot-product sequencer state encoding.
// Used by v_ram users, the layer controller and v_dot_ctrl.
package dnn_pkg;

  localparam int DNN_D_WIDTH   = 16;
  localparam int DNN_A_WIDTH   = 4;
  localparam int DNN_ACC_WIDTH = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dot_state_t;

endpackage

// File: rtl/v_dot_ctrl_if.sv
// Request/result bundle between the layer controller (master) and v_dot_ctrl (slave).
interface v_dot_ctrl_if
  import dnn_pkg::*;
#(
  parameter int A_WIDTH   = DNN_A_WIDTH,
  parameter int ACC_WIDTH = DNN_ACC_WIDTH
);

  logic                 start;
  logic [A_WIDTH-1:0]   base_v;
  logic [A_WIDTH-1:0]   base_w;
  logic [A_WIDTH:0]     len;
  logic                 busy;
  logic [ACC_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output start, base_v, base_w, len, result_ready,
    input  busy, result, result_valid
  );

  modport slave (
    input  start, base_v, base_w, len, result_ready,
    output busy, result, result_valid
  );

endinterface

// File: rtl/v_mac.sv
// Signed multiply-accumulate: acc <= acc + sext(a*b) when en, cleared by clr.
// One-cycle update; no backpressure, wraps two's complement at ACC_WIDTH.
module v_mac
  import dnn_pkg::*;
#(
  parameter int D_WIDTH   = DNN_D_WIDTH,
  parameter int ACC_WIDTH = DNN_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [D_WIDTH-1:0]   a,
  input  logic signed [D_WIDTH-1:0]   b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*D_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;

  assign prod     = a * b;
  assign prod_ext = ACC_WIDTH'(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/v_dot_ctrl.sv
// Dot-product sequencer over two registered-read RAMs; result_valid at start+len+2 (start+1 for len=0).
// Result is held until result_ready; start is ignored whenever busy.
module v_dot_ctrl
  import dnn_pkg::*;
#(
  parameter int D_WIDTH   = DNN_D_WIDTH,
  parameter int A_WIDTH   = DNN_A_WIDTH,
  parameter int ACC_WIDTH = DNN_ACC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  v_dot_ctrl_if.slave               ctl,
  output logic [A_WIDTH-1:0]        v_r_addr,
  output logic [A_WIDTH-1:0]        w_r_addr,
  input  logic signed [D_WIDTH-1:0] v_data,
  input  logic signed [D_WIDTH-1:0] w_data
);

  localparam logic [A_WIDTH:0] LEN_ONE = (A_WIDTH+1)'(1);

  dot_state_t                  state_q;
  dot_state_t                  state_d;
  logic [A_WIDTH:0]            rem_q;
  logic                        pipe_q;
  logic                        valid_q;
  logic                        accept;
  logic                        hs;
  logic signed [ACC_WIDTH-1:0] acc;

  assign accept = (state_q == ST_IDLE) && ctl.start;
  assign hs     = valid_q && ctl.result_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctl.start) begin
          state_d = (ctl.len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rem_q == LEN_ONE) begin
          state_d = ST_DRAIN;
        end
      end
      // DRAIN lasts exactly one cycle: the last issued read's data is on the bus.
      ST_DRAIN: begin
        if (pipe_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_r_addr <= '0;
      w_r_addr <= '0;
      rem_q    <= '0;
      pipe_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      // Read data arrives one cycle after its address was presented.
      pipe_q <= (state_q == ST_ISSUE);

      if (accept) begin
        v_r_addr <= ctl.base_v;
        w_r_addr <= ctl.base_w;
        rem_q    <= ctl.len;
      end else if (state_q == ST_ISSUE) begin
        rem_q <= rem_q - LEN_ONE;
        if (rem_q != LEN_ONE) begin
          v_r_addr <= v_r_addr + A_WIDTH'(1);
          w_r_addr <= w_r_addr + A_WIDTH'(1);
        end
      end

      if (hs) begin
        valid_q <= 1'b0;
      end else if (state_q == ST_DONE) begin
        valid_q <= 1'b1;
      end
    end
  end

  v_mac #(
    .D_WIDTH   (D_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (pipe_q),
    .a   (v_data),
    .b   (w_data),
    .acc (acc)
  );

  assign ctl.busy         = (state_q != ST_IDLE);
  assign ctl.result_valid = valid_q;
  assign ctl.result       = acc;

endmodule

// File: tb/tb_v_dot_ctrl.sv
// Directed bench for v_dot_ctrl with two behavioural registered-read RAMs.
module tb_v_dot_ctrl;
  import dnn_pkg::*;

  logic clk;
  logic rst;
  logic [3:0] v_r_addr;
  logic [3:0] w_r_addr;
  logic signed [15:0] v_data;
  logic signed [15:0] w_data;
  logic signed [15:0] vmem [16];
  logic signed [15:0] wmem [16];
  logic [3:0] vlog [16];

  int n_chk;
  int n_err;
  int lat;

  v_dot_ctrl_if #(.A_WIDTH(4), .ACC_WIDTH(40)) dif ();

  v_dot_ctrl #(.D_WIDTH(16), .A_WIDTH(4), .ACC_WIDTH(40)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctl      (dif),
    .v_r_addr (v_r_addr),
    .w_r_addr (w_r_addr),
    .v_data   (v_data),
    .w_data   (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    v_data <= vmem[v_r_addr];
    w_data <= wmem[w_r_addr];
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] dot_model(input int bv, input int bw, input int l);
    logic signed [39:0] s;
    s = '0;
    for (int k = 0; k < l; k++) begin
      s = s + vmem[(bv + k) % 16] * wmem[(bw + k) % 16];
    end
    return s;
  endfunction

  // Pulse start, then return the edge index (after the start edge) at which result_valid is seen.
  task automatic run(input int bv, input int bw, input int l, output int edge_n);
    @(negedge clk);
    dif.start  = 1'b1;
    dif.base_v = 4'(bv);
    dif.base_w = 4'(bw);
    dif.len    = 5'(l);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    edge_n = -1;
    check("busy_run", 40'(dif.busy), 40'd1);
    for (int e = 0; e < 40; e++) begin
      if (e < 16) vlog[e] = v_r_addr;
      if (dif.result_valid) begin
        edge_n = e;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_hs();
    @(posedge clk);
    #1;
    check("vld_drop", 40'(dif.result_valid), 40'd0);
    check("busy_drop", 40'(dif.busy), 40'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    vmem[0] = 16'sd1;    wmem[0] = 16'sd5;
    vmem[1] = 16'sd2;    wmem[1] = 16'sd6;
    vmem[2] = 16'sd3;    wmem[2] = 16'sd7;
    vmem[3] = 16'sd4;    wmem[3] = 16'sd8;
    vmem[4] = -16'sd3;   wmem[4] = 16'sd2;
    vmem[5] = 16'sh7FFF; wmem[5] = -16'sd1;
    for (int i = 6; i < 14; i++) begin
      vmem[i] = 16'(i * 10);
      wmem[i] = 16'(4 - i);
    end
    vmem[14] = -16'sd100; wmem[14] = -16'sd10;
    vmem[15] = 16'sd250;  wmem[15] = -16'sd11;

    rst = 1'b0;
    dif.start = 1'b0;
    dif.base_v = '0;
    dif.base_w = '0;
    dif.len = '0;
    dif.result_ready = 1'b1;
    #12;
    check("rst_busy", 40'(dif.busy), 40'd0);
    check("rst_vld", 40'(dif.result_valid), 40'd0);
    check("rst_res", dif.result, 40'd0);
    check("rst_vaddr", 40'(v_r_addr), 40'd0);
    check("rst_waddr", 40'(w_r_addr), 40'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic dot product
    run(0, 0, 4, lat);
    check("t1_lat", 40'(lat), 40'd6);
    check("t1_res", dif.result, 40'd70);
    finish_hs();

    // Signed operands
    run(4, 4, 2, lat);
    check("t2_lat", 40'(lat), 40'd4);
    check("t2_res", dif.result, 40'(-32773));
    finish_hs();

    // Address wrap past the top of the RAM
    run(14, 0, 4, lat);
    check("t3_lat", 40'(lat), 40'd6);
    check("t3_res", dif.result, 40'd1023);
    check("t3_model", dif.result, dot_model(14, 0, 4));
    check("t3_a0", 40'(vlog[0]), 40'd14);
    check("t3_a1", 40'(vlog[1]), 40'd15);
    check("t3_a2", 40'(vlog[2]), 40'd0);
    check("t3_a3", 40'(vlog[3]), 40'd1);
    finish_hs();

    // Empty and full-depth vectors
    run(3, 3, 0, lat);
    check("t4_len0_lat", 40'(lat), 40'd1);
    check("t4_len0_res", dif.result, 40'd0);
    finish_hs();
    run(0, 0, 16, lat);
    check("t4_full_lat", 40'(lat), 40'd18);
    check("t4_full_res", dif.result, dot_model(0, 0, 16));
    finish_hs();

    // Back-pressure: result held, starts ignored
    dif.result_ready = 1'b0;
    run(0, 0, 4, lat);
    check("t5_lat", 40'(lat), 40'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dif.start  = 1'b1;
      dif.base_v = 4'(i + 6);
      dif.len    = 5'd1;
      @(posedge clk);
      #1;
      check("t5_hold_res", dif.result, 40'd70);
      check("t5_hold_vld", 40'(dif.result_valid), 40'd1);
    end
    @(negedge clk);
    dif.result_ready = 1'b1;
    dif.start  = 1'b1;
    dif.base_v = 4'd8;
    dif.base_w = 4'd8;
    dif.len    = 5'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check("t5_hs_vld", 40'(dif.result_valid), 40'd0);
    check("t5_start_drop", 40'(dif.busy), 40'd0);
    run(4, 4, 2, lat);
    check("t5_re_lat", 40'(lat), 40'd4);
    check("t5_re_res", dif.result, 40'(-32773));
    finish_hs();

    // Reset in the middle of an ISSUE phase
    @(negedge clk);
    dif.start  = 1'b1;
    dif.base_v = 4'd0;
    dif.base_w = 4'd0;
    dif.len    = 5'd8;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t6_pre_addr", 40'(v_r_addr), 40'd2);
    rst = 1'b0;
    #1;
    check("t6_busy", 40'(dif.busy), 40'd0);
    check("t6_vld", 40'(dif.result_valid), 40'd0);
    check("t6_res", dif.result, 40'd0);
    check("t6_vaddr", 40'(v_r_addr), 40'd0);
    check("t6_waddr", 40'(w_r_addr), 40'd0);
    @(negedge clk);
    rst = 1'b1;
    run(0, 0, 4, lat);
    check("t6_lat", 40'(lat), 40'd6);
    check("t6_res_after", dif.result, 40'd70);
    finish_hs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
